// File: rtl/rv32_ifetch.sv
// RV32 instruction-fetch front end: one outstanding imem read, DEPTH-entry buffer to decode.
// Optional macro RV32_IFETCH_ALIGN_CHECK_EN turns misaligned PCs into marker entries instead of fetches.
module rv32_ifetch #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] pc,
   input  logic        flush,
   input  logic        halt,
   output logic        fetch_busy,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic        id_misalign
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        misalign;
   } entry_t;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

   state_t        state, state_nxt;
   entry_t        buf_q [DEPTH];
   entry_t        head, push_data;
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [AW:0]   count;
   logic [31:0]   addr_q;
   logic          can_issue, fetch_ok, mis_push, rsp_push, push, pop;

   assign can_issue = (state == IDLE) && !halt && !flush && (count < (AW+1)'(DEPTH));
`ifdef RV32_IFETCH_ALIGN_CHECK_EN
   assign mis_push  = can_issue && (pc[1:0] != 2'b00);
`else
   assign mis_push  = 1'b0;
`endif
   assign fetch_ok  = can_issue && !mis_push;

   always_comb begin
      state_nxt = state;
      rsp_push  = 1'b0;
      case (state)
         IDLE: if (fetch_ok) state_nxt = REQ;
         REQ: begin
            if (flush)         state_nxt = imem_gnt ? DROP : IDLE;
            else if (imem_gnt) state_nxt = WAIT;
         end
         WAIT: begin
            if (imem_rvalid) begin
               state_nxt = IDLE;
               rsp_push  = !flush;
            end else if (flush) begin
               state_nxt = DROP;
            end
         end
         // the abandoned response still has to drain before a new request may go out
         DROP: if (imem_rvalid) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         addr_q <= '0;
      end else begin
         state <= state_nxt;
         if (fetch_ok) addr_q <= {pc[31:2], 2'b00};
      end
   end

   assign push      = rsp_push | mis_push;
   assign push_data = mis_push ? '{pc: pc, instr: 32'h0, misalign: 1'b1}
                               : '{pc: addr_q, instr: imem_rdata, misalign: 1'b0};
   assign pop       = id_valid && id_ready && !flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            buf_q[wr_ptr] <= push_data;
            wr_ptr        <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   assign head        = buf_q[rd_ptr];
   assign id_valid    = (count != '0);
   assign id_pc       = head.pc;
   assign id_instr    = head.instr;
   // only marker entries carry a set bit, so this reads 0 when the check is compiled out
   assign id_misalign = head.misalign;

   assign imem_req   = (state == REQ);
   assign imem_addr  = addr_q;
   assign fetch_busy = ~((imem_req & imem_gnt) | mis_push);

endmodule

// File: tb/tb_rv32_ifetch.sv
// Bench for rv32_ifetch: directed scenarios plus a randomized run checked against a
// sequential-stream model (decode must see pc, pc+4, ... from each flush target).
module tb_rv32_ifetch;
   logic        clk = 1'b0;
   logic        rst_n, flush, halt, imem_gnt, imem_rvalid, id_ready;
   logic [31:0] pc, imem_rdata;
   logic        fetch_busy, imem_req, id_valid, id_misalign;
   logic [31:0] imem_addr, id_instr, id_pc;

   rv32_ifetch #(.DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n), .pc(pc), .flush(flush), .halt(halt),
      .fetch_busy(fetch_busy), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
      .id_pc(id_pc), .id_misalign(id_misalign)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0;
   int req_cnt = 0, fb_low_cnt = 0;
   int gnt_lat = 0, rv_lat = 0, g_cnt = 0, rv_cnt = 0;
   bit rnd_lat = 0, pend = 0, dead_seen = 0;
   logic [31:0] pend_addr, flush_tgt = '0;
   logic        s_req, s_fb, s_valid, s_mis;
   logic [31:0] s_addr, s_pc, s_instr;
   logic [31:0] obs_pc[$], obs_in[$];
   logic        obs_mis[$];

   // memory image
   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (a == 32'h100) return 32'h0000_0013;
      if (a == 32'h200) return 32'hDEAD_BEEF;
      return {a[15:0] ^ 16'hC3A5, a[31:16]} + 32'h1357;
   endfunction

   function automatic int pick_g();
      return rnd_lat ? int'($urandom_range(0, 2)) : gnt_lat;
   endfunction

   function automatic int pick_rv();
      return rnd_lat ? int'($urandom_range(0, 3)) : rv_lat;
   endfunction

   // One cycle: sample at negedge, then (posedge+1) advance PC unit and memory model.
   task automatic tick();
      @(negedge clk);
      s_req = imem_req; s_fb = fetch_busy; s_valid = id_valid; s_mis = id_misalign;
      s_addr = imem_addr; s_pc = id_pc; s_instr = id_instr;
      if (imem_req) req_cnt++;
      if (!fetch_busy) fb_low_cnt++;
      if (id_valid && id_instr == 32'hDEAD_BEEF) dead_seen = 1;
      if (id_valid && id_ready && !flush) begin
         obs_pc.push_back(id_pc); obs_in.push_back(id_instr); obs_mis.push_back(id_misalign);
      end
      @(posedge clk); #1;
      if (flush) pc = flush_tgt;
      else if (!s_fb) pc = pc + 32'd4;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = $urandom;
      if (pend) begin
         if (rv_cnt == 0) begin
            imem_rvalid = 1'b1; imem_rdata = mem_rd(pend_addr); pend = 0;
         end else rv_cnt--;
      end
      if (imem_req) begin
         if (g_cnt == 0) begin
            imem_gnt = 1'b1; pend = 1; pend_addr = imem_addr;
            rv_cnt = pick_rv(); g_cnt = pick_g();
         end else g_cnt--;
      end else g_cnt = pick_g();
   endtask

   task automatic do_flush(input logic [31:0] tgt);
      flush = 1'b1; flush_tgt = tgt;
      tick();
      flush = 1'b0;
      repeat (5) tick();
      obs_pc.delete(); obs_in.delete(); obs_mis.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; pc = '0; flush = 1'b0; halt = 1'b1; id_ready = 1'b1;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      #1;
      n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req); end
      n_chk++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
      n_chk++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", id_valid); end
      n_chk++; if (id_instr !== 32'h0 || id_pc !== 32'h0) begin n_fail++; $display("FAIL reset_id: instr %h pc %h want 0", id_instr, id_pc); end
      n_chk++; if (id_misalign !== 1'b0) begin n_fail++; $display("FAIL reset_mis: got %b want 0", id_misalign); end
      n_chk++; if (fetch_busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b want 1", fetch_busy); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      pc = 32'h100;
   endtask

   task automatic test_basic();
      int fb0;
      gnt_lat = 0; rv_lat = 0; id_ready = 1'b1;
      repeat (2) tick();
      fb0 = fb_low_cnt;
      halt = 1'b0;
      tick();  // pc sampled here
      halt = 1'b1;
      n_chk++; if (s_req !== 1'b0) begin n_fail++; $display("FAIL basic_t0_req: got %b want 0", s_req); end
      tick();
      n_chk++; if (s_req !== 1'b1 || s_fb !== 1'b0) begin n_fail++; $display("FAIL basic_t1_req: req %b busy %b want 1/0", s_req, s_fb); end
      n_chk++; if (s_addr !== 32'h100) begin n_fail++; $display("FAIL basic_addr: got %h want 100", s_addr); end
      tick();
      n_chk++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL basic_t2_valid: got %b want 0", s_valid); end
      tick();
      n_chk++; if (s_valid !== 1'b1 || s_pc !== 32'h100 || s_instr !== 32'h13)
         begin n_fail++; $display("FAIL basic_t3_head: valid %b pc %h instr %h want 1/100/13", s_valid, s_pc, s_instr); end
      repeat (2) tick();
      n_chk++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL basic_popped: got %b want 0", s_valid); end
      n_chk++; if (fb_low_cnt - fb0 != 1) begin n_fail++; $display("FAIL basic_busy_low: got %0d cycles want 1", fb_low_cnt - fb0); end
   endtask

   task automatic test_full();
      int r0;
      halt = 1'b1; id_ready = 1'b0;
      do_flush(32'h100);
      halt = 1'b0;
      repeat (10) tick();
      r0 = req_cnt;
      repeat (5) tick();
      n_chk++; if (req_cnt != r0) begin n_fail++; $display("FAIL full_no_req: got %0d reqs want 0", req_cnt - r0); end
      n_chk++; if (s_valid !== 1'b1 || s_pc !== 32'h100) begin n_fail++; $display("FAIL full_head: valid %b pc %h want 1/100", s_valid, s_pc); end
      id_ready = 1'b1;
      repeat (8) tick();
      n_chk++;
      if (obs_pc.size() < 3) begin n_fail++; $display("FAIL full_order: got %0d pops want >=3", obs_pc.size()); end
      else if (obs_pc[0] !== 32'h100 || obs_pc[1] !== 32'h104 || obs_pc[2] !== 32'h108)
         begin n_fail++; $display("FAIL full_order: got %h %h %h want 100 104 108", obs_pc[0], obs_pc[1], obs_pc[2]); end
      halt = 1'b1;
   endtask

   task automatic test_flush_wait();
      int r0;
      halt = 1'b1; id_ready = 1'b1; gnt_lat = 0; rv_lat = 2;
      do_flush(32'h200);
      dead_seen = 0;
      halt = 1'b0;
      tick();
      halt = 1'b1;
      tick();  // granted
      flush = 1'b1; flush_tgt = 32'h300;
      tick();  // WAIT + flush
      flush = 1'b0;
      r0 = req_cnt;
      repeat (3) tick();
      n_chk++; if (s_valid !== 1'b0 || req_cnt != r0) begin n_fail++; $display("FAIL flushw_drop: valid %b reqs %0d want 0/0", s_valid, req_cnt - r0); end
      rv_lat = 0; halt = 1'b0;
      repeat (8) tick();
      halt = 1'b1;
      n_chk++; if (dead_seen) begin n_fail++; $display("FAIL flushw_dead: got DEADBEEF at decode want none"); end
      n_chk++;
      if (obs_pc.size() == 0) begin n_fail++; $display("FAIL flushw_resume: got 0 pops want >=1"); end
      else if (obs_pc[0] !== 32'h300 || obs_in[0] !== mem_rd(32'h300))
         begin n_fail++; $display("FAIL flushw_resume: got pc %h instr %h want 300 %h", obs_pc[0], obs_in[0], mem_rd(32'h300)); end
   endtask

   task automatic test_flush_fifo();
      halt = 1'b1; id_ready = 1'b0;
      do_flush(32'h400);
      halt = 1'b0;
      repeat (10) tick();
      halt = 1'b1;
      tick();
      n_chk++; if (s_valid !== 1'b1 || s_pc !== 32'h400) begin n_fail++; $display("FAIL flushf_pre: valid %b pc %h want 1/400", s_valid, s_pc); end
      id_ready = 1'b1; flush = 1'b1; flush_tgt = 32'h500;
      tick();
      flush = 1'b0;
      tick();
      n_chk++; if (s_valid !== 1'b0 || obs_pc.size() != 0) begin n_fail++; $display("FAIL flushf_empty: valid %b pops %0d want 0/0", s_valid, obs_pc.size()); end
      halt = 1'b0;
      repeat (8) tick();
      halt = 1'b1;
      n_chk++;
      if (obs_pc.size() == 0) begin n_fail++; $display("FAIL flushf_next: got 0 pops want >=1"); end
      else if (obs_pc[0] !== 32'h500) begin n_fail++; $display("FAIL flushf_next: got %h want 500", obs_pc[0]); end
   endtask

   task automatic test_halt();
      int r0;
      halt = 1'b1; id_ready = 1'b0; gnt_lat = 0;
      do_flush(32'h600);
      rv_lat = 3; halt = 1'b0;
      tick();
      tick();  // granted
      halt = 1'b1;
      r0 = req_cnt;
      repeat (8) tick();
      n_chk++; if (req_cnt != r0) begin n_fail++; $display("FAIL halt_no_req: got %0d reqs want 0", req_cnt - r0); end
      n_chk++; if (s_valid !== 1'b1 || s_pc !== 32'h600 || s_instr !== mem_rd(32'h600))
         begin n_fail++; $display("FAIL halt_buffered: valid %b pc %h instr %h want 1/600/%h", s_valid, s_pc, s_instr, mem_rd(32'h600)); end
      rv_lat = 0; halt = 1'b0;
      repeat (4) tick();
      n_chk++; if (req_cnt == r0) begin n_fail++; $display("FAIL halt_resume: got 0 reqs want >0"); end
      halt = 1'b1; id_ready = 1'b1;
      repeat (6) tick();
   endtask

   task automatic test_align();
      halt = 1'b1; id_ready = 1'b0; gnt_lat = 0; rv_lat = 0;
      do_flush(32'h102);
      halt = 1'b0;
      tick();
      halt = 1'b1;
`ifdef RV32_IFETCH_ALIGN_CHECK_EN
      n_chk++; if (s_req !== 1'b0 || s_fb !== 1'b0) begin n_fail++; $display("FAIL align_mark: req %b busy %b want 0/0", s_req, s_fb); end
      tick();
      n_chk++; if (s_valid !== 1'b1 || s_mis !== 1'b1 || s_pc !== 32'h102 || s_req !== 1'b0)
         begin n_fail++; $display("FAIL align_entry: valid %b mis %b pc %h req %b want 1/1/102/0", s_valid, s_mis, s_pc, s_req); end
`else
      tick();
      n_chk++; if (s_req !== 1'b1 || s_addr !== 32'h100) begin n_fail++; $display("FAIL align_addr: req %b addr %h want 1/100", s_req, s_addr); end
      repeat (2) tick();
      n_chk++; if (s_mis !== 1'b0 || s_pc !== 32'h100) begin n_fail++; $display("FAIL align_entry: mis %b pc %h want 0/100", s_mis, s_pc); end
`endif
      id_ready = 1'b1;
      repeat (4) tick();
   endtask

   task automatic test_reset_mid();
      halt = 1'b1; id_ready = 1'b0; gnt_lat = 0; rv_lat = 0;
      do_flush(32'h700);
      halt = 1'b0;
      repeat (5) tick();
      #2 rst_n = 1'b0;
      #1;
      n_chk++; if (imem_req !== 1'b0 || fetch_busy !== 1'b1 || id_valid !== 1'b0 || id_pc !== 32'h0 || imem_addr !== 32'h0)
         begin n_fail++; $display("FAIL rstmid: req %b busy %b valid %b pc %h addr %h want 0/1/0/0/0", imem_req, fetch_busy, id_valid, id_pc, imem_addr); end
      imem_gnt = 1'b0; imem_rvalid = 1'b0; pend = 0; g_cnt = 0;
      @(posedge clk); #1;
      rst_n = 1'b1; pc = 32'h800; id_ready = 1'b1;
      obs_pc.delete(); obs_in.delete(); obs_mis.delete();
      repeat (8) tick();
      n_chk++;
      if (obs_pc.size() == 0) begin n_fail++; $display("FAIL rstmid_resume: got 0 pops want >=1"); end
      else if (obs_pc[0] !== 32'h800) begin n_fail++; $display("FAIL rstmid_resume: got %h want 800", obs_pc[0]); end
      halt = 1'b1;
   endtask

   task automatic test_random();
      logic [31:0] exp_next, r, p, ins;
      logic        m;
      int          pops = 0;
      halt = 1'b1;
      do_flush(32'h1_0000);
      exp_next = 32'h1_0000;
      rnd_lat = 1;
      for (int c = 0; c < 3000; c++) begin
         id_ready = ($urandom_range(0, 3) != 0);
         halt     = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 39) == 0) begin
            r = $urandom;
            flush = 1'b1; flush_tgt = {16'h0001, r[15:2], 2'b00};
         end
         tick();
         while (obs_pc.size() > 0) begin
            p = obs_pc.pop_front(); ins = obs_in.pop_front(); m = obs_mis.pop_front();
            pops++;
            n_chk++;
            if (p !== exp_next || ins !== mem_rd(exp_next) || m !== 1'b0)
               begin n_fail++; $display("FAIL rand_stream: got pc %h instr %h mis %b want %h %h 0", p, ins, m, exp_next, mem_rd(exp_next)); end
            exp_next = exp_next + 32'd4;
         end
         if (flush) exp_next = flush_tgt;
         flush = 1'b0;
      end
      rnd_lat = 0; halt = 1'b1;
      n_chk++; if (pops < 200) begin n_fail++; $display("FAIL rand_progress: got %0d pops want >=200", pops); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_full();
      test_flush_wait();
      test_flush_fifo();
      test_halt();
      test_align();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
